// File: rtl/yin_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : yin_frame_scheduler
// Description : Collects audio samples, launches YIN pitch analyses on a
//               window/hop schedule and filters the results into a held,
//               voiced/unvoiced period output with timeout/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module yin_frame_scheduler #(
    parameter int WINDOW_SIZE = 2048,
    parameter int HOP         = 512,
    parameter int TAU_LO      = 20,
    parameter int TAU_HI      = 2000,
    parameter int TIMEOUT     = 200000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        sample_valid_in,
    output logic        yin_start_out,
    input  logic        yin_valid_in,
    input  logic [10:0] yin_taumin_in,
    output logic [10:0] taumin_out,
    output logic        taumin_valid_out,
    output logic        voiced_out,
    output logic        timeout_err_out,
    output logic        overrun_out,
    output logic [15:0] frame_count_out
);

    localparam int c_SCW = $clog2(WINDOW_SIZE + 1);
    localparam int c_TOW = $clog2(TIMEOUT + 1);
    localparam int c_RJW = $clog2(HOLD_FRAMES + 1);

    localparam logic [c_SCW-1:0] c_WINDOW   = c_SCW'(WINDOW_SIZE);
    localparam logic [c_SCW-1:0] c_HOP      = c_SCW'(HOP);
    localparam logic [c_TOW-1:0] c_TO_LAST  = c_TOW'(TIMEOUT - 1);
    localparam logic [c_RJW-1:0] c_HOLD     = c_RJW'(HOLD_FRAMES);
    localparam logic [c_RJW-1:0] c_HOLD_M1  = c_RJW'(HOLD_FRAMES - 1);
    localparam logic [10:0]      c_TAU_LO   = 11'(TAU_LO);
    localparam logic [10:0]      c_TAU_HI   = 11'(TAU_HI);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [c_SCW-1:0] r_sample_cnt;
    logic [c_TOW-1:0] r_timeout_cnt;
    logic [c_RJW-1:0] r_reject_cnt;
    logic             r_first_frame;
    logic             r_timed_out;
    logic [10:0]      r_tau;

    logic [c_SCW-1:0] w_target;
    logic             w_cnt_inc;
    logic             w_timeout_hit;
    logic             w_accept;

    assign w_target      = r_first_frame ? c_WINDOW : c_HOP;
    assign w_cnt_inc     = sample_valid_in && (r_sample_cnt < w_target);
    assign w_timeout_hit = (r_timeout_cnt == c_TO_LAST);
    assign w_accept      = !r_timed_out && (r_tau >= c_TAU_LO) && (r_tau <= c_TAU_HI);
    assign yin_start_out = (r_state == S_ARM);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A low enable overrides every transition, including an in-flight analysis.
    always_comb begin
        w_state_next = r_state;
        if (!enable_in) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_FILL;
                S_FILL:  if (r_sample_cnt == w_target) w_state_next = S_ARM;
                S_ARM:   w_state_next = S_WAIT;
                S_WAIT:  if (yin_valid_in || w_timeout_hit) w_state_next = S_CHECK;
                S_CHECK: w_state_next = (r_sample_cnt >= c_HOP) ? S_ARM : S_FILL;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sample_cnt     <= '0;
            r_timeout_cnt    <= '0;
            r_reject_cnt     <= '0;
            r_first_frame    <= 1'b0;
            r_timed_out      <= 1'b0;
            r_tau            <= '0;
            taumin_out       <= '0;
            taumin_valid_out <= 1'b0;
            voiced_out       <= 1'b0;
            timeout_err_out  <= 1'b0;
            overrun_out      <= 1'b0;
            frame_count_out  <= '0;
        end else begin
            taumin_valid_out <= 1'b0;
            if (!enable_in) begin
                r_sample_cnt  <= '0;
                r_timeout_cnt <= '0;
                r_reject_cnt  <= '0;
            end else begin
                // A sample arriving in the ARM cycle belongs to the next hop.
                case (r_state)
                    S_IDLE: begin
                        r_sample_cnt  <= '0;
                        r_first_frame <= 1'b1;
                    end
                    S_ARM: begin
                        r_sample_cnt    <= c_SCW'(sample_valid_in);
                        r_first_frame   <= 1'b0;
                        r_timeout_cnt   <= '0;
                        frame_count_out <= frame_count_out + 16'd1;
                    end
                    default: begin
                        if (w_cnt_inc) r_sample_cnt <= r_sample_cnt + 1'b1;
                    end
                endcase

                if (r_state == S_WAIT) begin
                    r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    if (w_cnt_inc && (r_sample_cnt == w_target - 1'b1)) overrun_out <= 1'b1;
                    // A result in the final timeout cycle still wins.
                    if (yin_valid_in) begin
                        r_tau       <= yin_taumin_in;
                        r_timed_out <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_timed_out     <= 1'b1;
                        timeout_err_out <= 1'b1;
                    end
                end

                if (r_state == S_CHECK) begin
                    if (w_accept) begin
                        taumin_out       <= r_tau;
                        voiced_out       <= 1'b1;
                        r_reject_cnt     <= '0;
                        taumin_valid_out <= 1'b1;
                    end else if (r_reject_cnt < c_HOLD) begin
                        r_reject_cnt <= r_reject_cnt + 1'b1;
                        if (r_reject_cnt == c_HOLD_M1) begin
                            taumin_out       <= '0;
                            voiced_out       <= 1'b0;
                            taumin_valid_out <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_yin_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_yin_frame_scheduler
// Description : Scoreboard bench for yin_frame_scheduler with reduced sizes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yin_frame_scheduler;

    localparam int WS  = 32;
    localparam int HP  = 8;
    localparam int TLO = 20;
    localparam int THI = 2000;
    localparam int TO  = 200;
    localparam int HF  = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        enable_in = 1'b0;
    logic        sample_valid_in = 1'b0;
    logic        yin_valid_in = 1'b0;
    logic [10:0] yin_taumin_in = '0;
    logic        yin_start_out;
    logic [10:0] taumin_out;
    logic        taumin_valid_out;
    logic        voiced_out;
    logic        timeout_err_out;
    logic        overrun_out;
    logic [15:0] frame_count_out;

    yin_frame_scheduler #(
        .WINDOW_SIZE(WS), .HOP(HP), .TAU_LO(TLO), .TAU_HI(THI),
        .TIMEOUT(TO), .HOLD_FRAMES(HF)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .sample_valid_in(sample_valid_in), .yin_start_out(yin_start_out),
        .yin_valid_in(yin_valid_in), .yin_taumin_in(yin_taumin_in),
        .taumin_out(taumin_out), .taumin_valid_out(taumin_valid_out),
        .voiced_out(voiced_out), .timeout_err_out(timeout_err_out),
        .overrun_out(overrun_out), .frame_count_out(frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [10:0] tau;
        logic        voiced;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          n_starts = 0;
    int          start_cycle = 0;
    int          m_rej = 0;
    logic [10:0] m_tau = '0;
    logic        m_voiced = 1'b0;

    always @(posedge clk_in) cycle <= cycle + 1;

    // Result pulses are popped against the scoreboard, including their cycle.
    always @(negedge clk_in) begin : mon
        exp_t e;
        if (yin_start_out) begin
            n_starts++;
            start_cycle = cycle;
        end
        if (taumin_valid_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got tau=%0d voiced=%0b at cycle %0d, required no pulse",
                         taumin_out, voiced_out, cycle);
            end else begin
                e = sb.pop_front();
                if (taumin_out !== e.tau || voiced_out !== e.voiced || cycle != e.cyc) begin
                    errors++;
                    $display("FAIL result_pulse got tau=%0d voiced=%0b cycle=%0d, required tau=%0d voiced=%0b cycle=%0d",
                             taumin_out, voiced_out, cycle, e.tau, e.voiced, e.cyc);
                end
            end
        end else if (sb.size() > 0 && cycle > sb[0].cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_pulse none at cycle %0d, required tau=%0d voiced=%0b",
                     e.cyc, e.tau, e.voiced);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid_in = 1'b1;
            step();
            sample_valid_in = 1'b0;
        end
    endtask

    task automatic wait_start(input int target, input string name);
        int i;
        i = 0;
        while (n_starts < target && i < 400) begin
            step();
            i++;
        end
        checks++;
        if (n_starts < target) begin
            errors++;
            $display("FAIL %s start count %0d, required %0d within bound", name, n_starts, target);
        end
    endtask

    task automatic model_result(input logic [10:0] tau, input bit tmo, input int cyc);
        if (!tmo && tau >= TLO && tau <= THI) begin
            m_tau    = tau;
            m_voiced = 1'b1;
            m_rej    = 0;
            sb.push_back('{tau, 1'b1, cyc});
        end else if (m_rej < HF) begin
            m_rej++;
            if (m_rej == HF) begin
                m_tau    = '0;
                m_voiced = 1'b0;
                sb.push_back('{11'd0, 1'b0, cyc});
            end
        end
    endtask

    task automatic send_result(input logic [10:0] tau);
        yin_valid_in  = 1'b1;
        yin_taumin_in = tau;
        model_result(tau, 1'b0, cycle + 2);
        step();
        yin_valid_in = 1'b0;
    endtask

    // Entered during WAIT; leaves in the first WAIT cycle of the next frame.
    task automatic run_frame(input logic [10:0] tau, input string name);
        int t;
        step();
        send_result(tau);
        step();
        step();
        checks++;
        if (taumin_out !== m_tau || voiced_out !== m_voiced) begin
            errors++;
            $display("FAIL %s got tau=%0d voiced=%0b, required tau=%0d voiced=%0b",
                     name, taumin_out, voiced_out, m_tau, m_voiced);
        end
        t = n_starts + 1;
        send_samples(HP);
        wait_start(t, name);
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (taumin_out !== 11'd0 || voiced_out !== 1'b0 || taumin_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_result got tau=%0d voiced=%0b valid=%0b, required 0 0 0",
                     taumin_out, voiced_out, taumin_valid_out);
        end
        checks++;
        if (yin_start_out !== 1'b0 || timeout_err_out !== 1'b0 || overrun_out !== 1'b0 ||
            frame_count_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_flags got start=%0b to=%0b ov=%0b fc=%0d, required 0 0 0 0",
                     yin_start_out, timeout_err_out, overrun_out, frame_count_out);
        end
        rst_in    = 1'b1;
        enable_in = 1'b1;
        step();
    endtask

    task automatic test_first_window();
        send_samples(WS - 1);
        repeat (3) step();
        checks++;
        if (n_starts !== 0) begin
            errors++;
            $display("FAIL early_start got %0d starts, required 0", n_starts);
        end
        send_samples(1);
        wait_start(1, "first_start");
        step();
        checks++;
        if (frame_count_out !== 16'd1 || n_starts !== 1 || yin_start_out !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_count got fc=%0d starts=%0d start=%0b, required 1 1 0",
                     frame_count_out, n_starts, yin_start_out);
        end
        run_frame(11'd300, "accept_300");
        checks++;
        if (frame_count_out !== 16'd2) begin
            errors++;
            $display("FAIL second_frame_count got %0d, required 2", frame_count_out);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) run_frame(11'd5, "hold_reject");
    endtask

    task automatic test_tau_bounds();
        run_frame(11'd19, "tau_below_lo");
        run_frame(11'd20, "tau_at_lo");
        run_frame(11'd2001, "tau_above_hi");
        run_frame(11'd2000, "tau_at_hi");
    endtask

    task automatic test_near_timeout();
        int t;
        repeat (TO - 1) step();
        send_result(11'd250);
        step();
        step();
        checks++;
        if (timeout_err_out !== 1'b0 || taumin_out !== 11'd250) begin
            errors++;
            $display("FAIL last_cycle_result got to=%0b tau=%0d, required to=0 tau=250",
                     timeout_err_out, taumin_out);
        end
        t = n_starts + 1;
        send_samples(HP);
        wait_start(t, "near_timeout_next");
    endtask

    task automatic test_timeout();
        int t;
        model_result(11'd0, 1'b1, cycle + TO + 1);
        repeat (TO + 3) step();
        checks++;
        if (timeout_err_out !== 1'b1 || taumin_out !== 11'd250 || voiced_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout got to=%0b tau=%0d voiced=%0b, required 1 250 1",
                     timeout_err_out, taumin_out, voiced_out);
        end
        t = n_starts + 1;
        send_samples(HP);
        wait_start(t, "timeout_next");
        run_frame(11'd5, "after_timeout_rej2");
        run_frame(11'd5, "after_timeout_rej3");
        run_frame(11'd5, "after_timeout_rej4");
        run_frame(11'd600, "accept_600");
    endtask

    task automatic test_overrun();
        int k;
        int s0;
        checks++;
        if (overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early got %0b, required 0", overrun_out);
        end
        send_samples(HP);
        step();
        checks++;
        if (overrun_out !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got %0b, required 1", overrun_out);
        end
        s0 = n_starts;
        k  = cycle;
        send_result(11'd400);
        step();
        step();
        checks++;
        if (n_starts !== s0 + 1 || start_cycle != k + 2) begin
            errors++;
            $display("FAIL check_to_arm got starts=%0d cycle=%0d, required starts=%0d cycle=%0d",
                     n_starts, start_cycle, s0 + 1, k + 2);
        end
    endtask

    task automatic test_reset_mid_wait();
        int s0;
        rst_in       = 1'b0;
        yin_valid_in = 1'b1;
        yin_taumin_in = 11'd300;
        #1;
        checks++;
        if (taumin_out !== 11'd0 || voiced_out !== 1'b0 || yin_start_out !== 1'b0 ||
            timeout_err_out !== 1'b0 || overrun_out !== 1'b0 || frame_count_out !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got tau=%0d v=%0b st=%0b to=%0b ov=%0b fc=%0d, required all 0",
                     taumin_out, voiced_out, yin_start_out, timeout_err_out, overrun_out, frame_count_out);
        end
        m_rej    = 0;
        m_tau    = '0;
        m_voiced = 1'b0;
        step();
        yin_valid_in = 1'b0;
        step();
        rst_in = 1'b1;
        step();
        yin_valid_in = 1'b1;
        step();
        yin_valid_in = 1'b0;
        s0 = n_starts;
        send_samples(WS - 1);
        repeat (3) step();
        checks++;
        if (n_starts !== s0) begin
            errors++;
            $display("FAIL reset_refill got %0d starts, required %0d", n_starts, s0);
        end
        send_samples(1);
        wait_start(s0 + 1, "reset_refill_start");
        checks++;
        if (frame_count_out !== 16'd1) begin
            errors++;
            $display("FAIL reset_frame_count got %0d, required 1", frame_count_out);
        end
    endtask

    task automatic test_enable_low_mid_fill();
        int s0;
        step();
        send_result(11'd500);
        repeat (3) step();
        send_samples(3);
        enable_in = 1'b0;
        step();
        step();
        s0 = n_starts;
        checks++;
        if (taumin_out !== 11'd500 || voiced_out !== 1'b1 || frame_count_out !== 16'd1) begin
            errors++;
            $display("FAIL disable_hold got tau=%0d voiced=%0b fc=%0d, required 500 1 1",
                     taumin_out, voiced_out, frame_count_out);
        end
        enable_in = 1'b1;
        step();
        send_samples(WS - 1);
        repeat (3) step();
        checks++;
        if (n_starts !== s0) begin
            errors++;
            $display("FAIL enable_refill got %0d starts, required %0d", n_starts, s0);
        end
        send_samples(1);
        wait_start(s0 + 1, "enable_refill_start");
        checks++;
        if (frame_count_out !== 16'd2) begin
            errors++;
            $display("FAIL enable_frame_count got %0d, required 2", frame_count_out);
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_hold();
        test_tau_bounds();
        test_near_timeout();
        test_timeout();
        test_overrun();
        test_reset_mid_wait();
        test_enable_low_mid_fill();
        enable_in = 1'b0;
        repeat (5) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/yin_frame_scheduler.md
YIN_FRAME_SCHEDULER -- requirements
Module: yin_frame_scheduler

Interface
REQ-001 SHALL have parameter WINDOW_SIZE, default 2048: samples that must be collected before the first analysis.
REQ-002 SHALL have parameter HOP, default 512: new samples required between later analyses (1 <= HOP <= WINDOW_SIZE).
REQ-003 SHALL have parameter TAU_LO, default 20: smallest taumin accepted as voiced.
REQ-004 SHALL have parameter TAU_HI, default 2000: largest taumin accepted as voiced.
REQ-005 SHALL have parameter TIMEOUT, default 200000: clock cycles allowed from start to yin result.
REQ-006 SHALL have parameter HOLD_FRAMES, default 4: consecutive rejected frames before output drops to unvoiced.
REQ-007 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-008 rst_in  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-009 enable_in  input  1  run request; 0 forces IDLE.
REQ-010 sample_valid_in  input  1  one-cycle strobe per new audio sample.
REQ-011 yin_start_out  output  1  one-cycle pulse launching a yin analysis.
REQ-012 yin_valid_in  input  1  one-cycle strobe: yin result ready.
REQ-013 yin_taumin_in  input  11  yin period result, sampled when yin_valid_in=1.
REQ-014 taumin_out  output  11  last published period (0 = unvoiced).
REQ-015 taumin_valid_out  output  1  one-cycle pulse when taumin_out is updated.
REQ-016 voiced_out  output  1  1 while taumin_out holds an accepted period.
REQ-017 timeout_err_out  output  1  sticky: a yin analysis timed out.
REQ-018 overrun_out  output  1  sticky: HOP samples arrived before the analysis finished.
REQ-019 frame_count_out  output  16  number of yin_start_out pulses issued, modulo 2^16.

Function
REQ-020 SHALL implement the FSM states IDLE, FILL, ARM, WAIT and CHECK.
REQ-021 IDLE: on enable_in=1, go to FILL with sample_cnt=0 and first_frame=1.
REQ-022 sample_cnt SHALL increment on each sample_valid_in in every state except IDLE.
REQ-023 sample_cnt SHALL saturate at its target: WINDOW_SIZE when first_frame=1, otherwise HOP.
REQ-024 FILL: go to ARM in the cycle after sample_cnt reaches its target.
REQ-025 ARM: yin_start_out=1 for exactly one cycle.
REQ-026 ARM: in the same cycle, frame_count_out increments (wrapping 0xFFFF->0), sample_cnt clears, first_frame clears and timeout_cnt clears.
REQ-027 ARM: go to WAIT next cycle.
REQ-028 A sample_valid_in in the ARM cycle SHALL count as 1 after the clear.
REQ-029 WAIT: timeout_cnt increments every cycle.
REQ-030 WAIT: yin_valid_in=1 latches yin_taumin_in and moves to CHECK.
REQ-031 WAIT: timeout_cnt reaching TIMEOUT-1 without yin_valid_in sets timeout_err_out and moves to CHECK as a rejected frame.
REQ-032 If yin_valid_in and the timeout occur in the same cycle, yin_valid_in SHALL win and the frame is not a timeout.
REQ-033 Reaching the HOP target while in WAIT SHALL set overrun_out; sample_cnt stays saturated.
REQ-034 yin_valid_in outside WAIT SHALL be ignored.
REQ-035 CHECK (one cycle): if TAU_LO <= tau <= TAU_HI, accept: taumin_out=tau, voiced_out=1, reject_cnt=0, pulse taumin_valid_out.
REQ-036 CHECK, otherwise (out of range or timeout): reject_cnt increments and saturates at HOLD_FRAMES.
REQ-037 On the reject that reaches HOLD_FRAMES: taumin_out=0, voiced_out=0, pulse taumin_valid_out once.
REQ-038 On earlier rejects, and later rejects while saturated: taumin_out is held and no pulse is issued.
REQ-039 CHECK exit: go to ARM if sample_cnt >= HOP, else go to FILL.
REQ-040 Latency from yin_valid_in to taumin_valid_out SHALL be exactly 2 cycles: the WAIT capture edge, then the CHECK-cycle register update.
REQ-041 enable_in=0 in any state SHALL force IDLE on the next edge.
REQ-042 On that forced IDLE: sample_cnt, timeout_cnt and reject_cnt clear; no pulse is issued; taumin_out, voiced_out, the sticky flags and frame_count_out are held.
REQ-043 When enable_in returns to 1, a full WINDOW_SIZE refill SHALL be required.

Reset
REQ-044 rst_in=0 SHALL immediately force state IDLE and clear all counters.
REQ-045 rst_in=0 SHALL immediately clear first_frame and every output: taumin_out=0, taumin_valid_out=0, yin_start_out=0, voiced_out=0, timeout_err_out=0, overrun_out=0, frame_count_out=0.
REQ-046 Reset release SHALL take effect on a clock edge; the first FSM move is on the first edge with rst_in=1.
REQ-047 Reset asserted during WAIT SHALL abandon the analysis with no pulse.

Verification
REQ-048 Defaults, enable=1, 2048 strobes -> exactly one yin_start_out, frame_count_out=1; 512 more strobes plus a result -> second start.
REQ-049 Result 300 in WAIT -> two cycles later taumin_out=300, voiced_out=1, one taumin_valid_out pulse.
REQ-050 Results 5, 5, 5, 5 after an accepted 300 -> taumin_out stays 300 for three frames; fourth reject gives taumin_out=0, voiced_out=0, one pulse.
REQ-051 No result for 200000 cycles -> timeout_err_out=1 and reject_cnt increments; yin_valid_in on the final timeout cycle -> accepted, flag stays 0.
REQ-052 512 strobes during WAIT -> overrun_out=1; CHECK goes straight to ARM.
REQ-053 rst_in low mid-WAIT, and separately enable_in low mid-FILL -> IDLE with no pulse; re-enable requires 2048 strobes before the next start.
